// File: rtl/tokenizer_pkg.sv
// Shared types and helpers for the Forth word tokenizer.
package tokenizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        COLLECT,
        EMIT,
        DONE
    } state_e;

    localparam logic [7:0] DEFAULT_EOL = 8'h0A;
    localparam logic [7:0] DEFAULT_WC  = 8'h20;

    // Characters are passed zero-extended so any WIDTH up to 32 works.
    function automatic logic is_delim(input logic [31:0] ch,
                                      input logic [31:0] eol,
                                      input logic [31:0] wc);
        return (ch == eol) || (ch == wc);
    endfunction

endpackage

// File: rtl/word_tokenizer_tok_buffer.sv
// Token assembly register: start a new word, append characters, and flag
// words that overflow the TOK_LEN slots.
module tok_buffer #(
    parameter int WIDTH   = 8,
    parameter int TOK_LEN = 8,
    parameter int TB      = $clog2(TOK_LEN + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_append,
    input  logic [WIDTH-1:0]         i_char,
    output logic [TOK_LEN*WIDTH-1:0] o_tok,
    output logic [TB-1:0]            o_len,
    output logic                     o_trunc
);

    logic [TOK_LEN*WIDTH-1:0] tok_q, tok_d;
    logic [TB-1:0]            len_q, len_d;
    logic                     trunc_q, trunc_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave it unassigned and infer a latch.
        tok_d   = tok_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        if (i_start) begin
            tok_d              = '0;
            tok_d[WIDTH-1:0]   = i_char;
            len_d              = TB'(1);
            trunc_d            = 1'b0;
        end else if (i_append) begin
            if (len_q < TB'(TOK_LEN)) begin
                for (int k = 0; k < TOK_LEN; k++) begin
                    if (len_q == TB'(k)) tok_d[k*WIDTH +: WIDTH] = i_char;
                end
                len_d = len_q + TB'(1);
            end else begin
                trunc_d = 1'b1;
            end
        end
    end

    // NOTE: the character store is reset as well, so outputs read 0 after reset rather than stale data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            tok_q   <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            tok_q   <= tok_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

    assign o_tok   = tok_q;
    assign o_len   = len_q;
    assign o_trunc = trunc_q;

endmodule

// File: rtl/word_tokenizer.sv
// Line-at-a-time word tokenizer: latches a terminal line, walks it one
// character per enabled cycle and hands whole words to the parser.
module word_tokenizer
    import tokenizer_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               LENGTH  = 16,
    parameter int               TOK_LEN = 8,
    parameter logic [WIDTH-1:0] EOL     = WIDTH'(DEFAULT_EOL),
    parameter logic [WIDTH-1:0] WC      = WIDTH'(DEFAULT_WC),
    parameter int               LB      = $clog2(LENGTH + 1),
    parameter int               TB      = $clog2(TOK_LEN + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [LENGTH*WIDTH-1:0]  i_line,
    input  logic [LB-1:0]            i_len,
    input  logic                     i_ready,
    output logic                     o_line_ack,
    output logic                     o_busy,
    output logic [TOK_LEN*WIDTH-1:0] o_tok,
    output logic [TB-1:0]            o_tok_len,
    output logic                     o_tok_trunc,
    output logic                     o_tok_valid,
    input  logic                     i_tok_ready,
    output logic                     o_done,
    output logic [LB-1:0]            o_tok_count
);

    state_e                  state_q, state_d;
    logic [LENGTH*WIDTH-1:0] line_q, line_d;
    logic [LB-1:0]           len_q, len_d;
    logic [LB-1:0]           idx_q, idx_d;
    logic [LB-1:0]           count_q, count_d;
    logic                    eol_hit_q, eol_hit_d;
    logic                    ack_q, ack_d;

    logic [WIDTH-1:0] cur_char;
    logic             at_end;
    logic             tok_start, tok_append;

    // Explicit mux keeps the select in range even when idx has reached len.
    always_comb begin
        cur_char = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (idx_q == LB'(k)) cur_char = line_q[k*WIDTH +: WIDTH];
        end
    end

    assign at_end = (idx_q == len_q);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        len_d      = len_q;
        idx_d      = idx_q;
        count_d    = count_q;
        eol_hit_d  = eol_hit_q;
        ack_d      = ack_q;
        tok_start  = 1'b0;
        tok_append = 1'b0;
        if (i_en) begin
            ack_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_ready) begin
                        line_d  = i_line;
                        len_d   = (i_len > LB'(LENGTH)) ? LB'(LENGTH) : i_len;
                        idx_d   = '0;
                        count_d = '0;
                        ack_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (at_end) begin
                        state_d = DONE;
                    end else if (cur_char == EOL) begin
                        idx_d   = idx_q + LB'(1);
                        state_d = DONE;
                    end else if (cur_char == WC) begin
                        idx_d = idx_q + LB'(1);
                    end else begin
                        tok_start = 1'b1;
                        idx_d     = idx_q + LB'(1);
                        state_d   = COLLECT;
                    end
                end
                COLLECT: begin
                    if (at_end) begin
                        state_d = EMIT;
                    end else if (is_delim(32'(cur_char), 32'(EOL), 32'(WC))) begin
                        eol_hit_d = (cur_char == EOL);
                        idx_d     = idx_q + LB'(1);
                        state_d   = EMIT;
                    end else begin
                        tok_append = 1'b1;
                        idx_d      = idx_q + LB'(1);
                    end
                end
                EMIT: begin
                    if (i_tok_ready) begin
                        count_d = (count_q == '1) ? count_q : count_q + LB'(1);
                        state_d = (eol_hit_q || at_end) ? DONE : SKIP;
                    end
                end
                DONE: begin
                    eol_hit_d = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            line_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            eol_hit_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            eol_hit_q <= eol_hit_d;
            ack_q     <= ack_d;
        end
    end

    tok_buffer #(
        .WIDTH   (WIDTH),
        .TOK_LEN (TOK_LEN),
        .TB      (TB)
    ) u_tok_buffer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (tok_start),
        .i_append (tok_append),
        .i_char   (cur_char),
        .o_tok    (o_tok),
        .o_len    (o_tok_len),
        .o_trunc  (o_tok_trunc)
    );

    assign o_line_ack  = ack_q;
    assign o_busy      = (state_q != IDLE);
    assign o_tok_valid = (state_q == EMIT);
    assign o_done      = (state_q == DONE);
    assign o_tok_count = o_done ? count_q : '0;

endmodule
